wb_ram_32_byte_lane_ctrl: RTL
=============================

Name: wb_ram_32_byte_lane_ctrl

Overview:
- 32-bit Wishbone B3 slave front end for the on-chip RAM.
- Decodes each bus cycle into four 8-bit byte-lane accesses. Each lane drives one generic_single_port_synchronous_ram_8_from_32 instance.
- Lane 0 = bits [31:24] (big-endian byte offset 0), lane 3 = bits [7:0].
- Generates per-lane write enables from wb_sel_i and a shared lane address, reassembles read data, and times wb_ack_o to the RAM's one-cycle registered-address read latency.

Parameters:
- ADDR_WIDTH, 11, per-lane word address width; RAM size = 4*2^ADDR_WIDTH bytes.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address; bits [ADDR_WIDTH+1:2] used, others ignored (aliasing).
- wb_sel_i  in  4  byte selects; sel[3] = bits [31:24].
- wb_dat_i  in  32  write data.
- wb_cti_i  in  3  cycle type identifier.
- wb_bte_i  in  2  burst type extension.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge, registered.
- lane_addr_o  out  ADDR_WIDTH  shared address to all four lane RAMs.
- lane_we_o  out  4  lane write enables; bit 0 = lane 0 = [31:24].
- lane_dat_o  out  32  write data; lane k gets bits [31-8k:24-8k].
- lane_dat_i  in  32  concatenated lane data_o, same packing.

Behaviour:
- Reset: wb_ack_o=0, lane_we_o=0, state=IDLE, internal burst address=0. A reset asserted mid-cycle aborts the cycle: no ack and no lane write in any reset cycle. The master must restart.
- lane_dat_o = wb_dat_i and wb_dat_o = lane_dat_i, both combinational pass-through. wb_dat_o is valid only while wb_ack_o=1.
- Request: req = wb_cyc_i & wb_stb_i.
- States: IDLE, ACK, BURST (BURST exists only with the optional feature).
- IDLE:
  - lane_addr_o = wb_adr_i[ADDR_WIDTH+1:2].
  - lane_we_o[k] = req & wb_we_i & wb_sel_i[3-k].
  - On req: next state ACK and wb_ack_o<=1. Latency is one cycle: the write lands at the request edge, and read data appears with ack.
- ACK:
  - wb_ack_o is high for exactly this cycle and lane_we_o=0.
  - lane_addr_o = registered beat address; without bursts the value is don't-care.
  - Next state IDLE, wb_ack_o<=0. Classic single access therefore costs 2 cycles; back-to-back stb produces ack on alternate cycles.
- wb_sel_i=0 write: acked normally, no lane written.
- Read ignores wb_sel_i; all four lanes are returned.
- wb_cyc_i dropping while ack is pending: ack still pulses for one cycle, and the master ignores it.

Optional Feature:
- Macro: WB_RAM_BURST_EN.
- Defined: registered-feedback incrementing bursts are supported.
  - A req in IDLE with wb_cti_i=3'b010 enters BURST instead of ACK.
  - A burst beat address register holds the word address of the current beat.
  - In BURST, wb_ack_o=1 on every cycle while req holds. The beat address advances by 1 per acked beat, wrapping within 4/8/16-word blocks for wb_bte_i = 01/10/11, and linearly (mod 2^ADDR_WIDTH) for 00.
  - Reads: lane_addr_o = next beat address, so data is ready on the following ack.
  - Writes: lane_addr_o = wb_adr_i word bits and lane_we_o follows wb_sel_i on each acked beat.
  - Beat with wb_cti_i=3'b111: final ack, then IDLE.
  - req dropping (wait state): ack deasserts, the address holds, and streaming resumes when req returns.
  - cti=000 or 111 in IDLE behaves as a classic single access.
- Undefined: cti/bte are ignored, every access is classic, and BURST logic is absent.

Test Plan:
1. Reset, then write adr=0x10, sel=4'b1111, dat=0xDEADBEEF. Expect: lane_we_o=4'b1111 and lane_addr_o=4 at the edge, ack the next cycle. Read back adr=0x10: dat_o=0xDEADBEEF with ack one cycle after stb.
2. Write adr=0x10, sel=4'b0100, dat=0x00AA0000 over the scenario-1 contents. Expect: only lane_we_o[1] high; readback 0xDEAABEEF.
3. Hold stb for 4 classic reads. Expect: ack pattern 0,1,0,1,0,1,0,1 and never two consecutive acks.
4. Assert rst_i in the cycle after a write request, before ack. Expect: wb_ack_o=0 and no further lane_we_o pulse. After reset, IDLE accepts a new request.
5. With WB_RAM_BURST_EN, run a 4-beat wrap4 read at adr=0x18 (cti 010,010,010,111; bte=01). Expect: acks on 4 consecutive cycles, word addresses 6,7,4,5, data matching preloaded lanes.
6. With WB_RAM_BURST_EN, drop stb for 2 cycles mid linear burst. Expect: ack low for those cycles, address held, and the next beat returns the correct word.

Source files
------------

// File: rtl/wb_ram_32_byte_lane_ctrl.sv
// wb_ram_32_byte_lane_ctrl: Wishbone B3 32-bit slave splitting each access into four 8-bit RAM byte lanes
// Optional feature macro: WB_RAM_BURST_EN (registered-feedback incrementing bursts; undefined = classic only)
// Ports: clk_i/rst_i clock and sync active-high reset; wb_* Wishbone slave side;
//        lane_addr_o/lane_we_o/lane_dat_o drive four lane RAMs (lane 0 = bits [31:24]); lane_dat_i is their read data
module wb_ram_32_byte_lane_ctrl #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] lane_addr_o,
  output logic [3:0]            lane_we_o,
  output logic [31:0]           lane_dat_o,
  input  logic [31:0]           lane_dat_i
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  logic [1:0]            state_q;
  logic                  ack_q;
  logic                  req;
  logic [ADDR_WIDTH-1:0] word;
  logic [3:0]            sel_lane;
  logic                  unused_ok;
  assign req        = wb_cyc_i & wb_stb_i;
  assign word       = wb_adr_i[ADDR_WIDTH+1:2];
  // lane k is written by sel[3-k], so the select vector is bit-reversed
  assign sel_lane   = {wb_sel_i[0], wb_sel_i[1], wb_sel_i[2], wb_sel_i[3]};
  assign lane_dat_o = wb_dat_i;
  assign wb_dat_o   = lane_dat_i;
`ifdef WB_RAM_BURST_EN
  logic [ADDR_WIDTH-1:0] beat_q, mask, nxt;
  logic                  in_burst;
  assign unused_ok = &{1'b0, wb_adr_i};
  // wrap boundary: only the masked low bits of the beat address increment
  always_comb begin
    mask = wb_bte_i == 2'b01 ? ADDR_WIDTH'(3) :
           wb_bte_i == 2'b10 ? ADDR_WIDTH'(7) :
           wb_bte_i == 2'b11 ? ADDR_WIDTH'(15) : '1;
    nxt  = (beat_q & ~mask) | ((beat_q + 1'b1) & mask);
  end
  assign in_burst = state_q == BURST;
  // burst acks follow req directly so a wait state stalls the stream in the same cycle
  assign wb_ack_o = (ack_q | (in_burst & req)) & ~rst_i;
  // burst reads present the next beat so its data is ready on the following ack
  assign lane_addr_o = state_q == ACK ? beat_q :
                       (in_burst & ~wb_we_i) ? (req ? nxt : beat_q) : word;
  assign lane_we_o = ((state_q == IDLE | in_burst) & req & wb_we_i & ~rst_i) ? sel_lane : 4'b0000;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_q == IDLE ? (req ? (wb_cti_i == 3'b010 ? BURST : ACK) : IDLE) :
                 in_burst ? ((req & wb_cti_i == 3'b111) ? IDLE : BURST) : IDLE;
      ack_q   <= state_q == IDLE & req & wb_cti_i != 3'b010;
      beat_q  <= state_q == IDLE ? word : (in_burst & req) ? nxt : beat_q;
    end
  end
`else
  assign unused_ok   = &{1'b0, wb_adr_i, wb_cti_i, wb_bte_i};
  assign wb_ack_o    = ack_q & ~rst_i;
  assign lane_addr_o = word;
  assign lane_we_o   = (state_q == IDLE & req & wb_we_i & ~rst_i) ? sel_lane : 4'b0000;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= (state_q == IDLE & req) ? ACK : IDLE;
      ack_q   <= state_q == IDLE & req;
    end
  end
`endif
endmodule
